// File: rtl/wb_req_slice_if.sv
// Wishbone classic bus bundle used on both sides of wb_req_slice.
// The master modport drives the request and samples the response; the slave
// modport is the mirror image. dat_w carries write data, dat_r read data.
interface wb_req_slice_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                      cyc;
   logic                      stb;
   logic                      we;
   logic [ADDR_WIDTH-1:0]     adr;
   logic [DATA_WIDTH-1:0]     dat_w;
   logic [DATA_WIDTH/8-1:0]   sel;
   logic [2:0]                cti;
   logic [1:0]                bte;
   logic                      ack;
   logic                      err;
   logic                      rty;
   logic [DATA_WIDTH-1:0]     dat_r;

   modport master (
      output cyc, stb, we, adr, dat_w, sel, cti, bte,
      input  ack, err, rty, dat_r
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel, cti, bte,
      output ack, err, rty, dat_r
   );
endinterface

// File: rtl/wb_req_slice.sv
// wb_req_slice: registered Wishbone request/response slice placed in front of
// the Wishbone-to-AXI bridge. Every output comes from a flop, upstream bursts
// are split into classic single-beat cycles, and the downstream request stays
// frozen until the downstream answers, even if the upstream walks away.
// Optional feature macro: WB_TIMEOUT_EN (downstream timeout with DRAIN state).
module wb_req_slice #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic            clk,
   input logic            rst,
   wb_req_slice_if.slave  s_wb,
   wb_req_slice_if.master m_wb
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RESP  = 2'd2
`ifdef WB_TIMEOUT_EN
      , DRAIN = 2'd3
`endif
   } state_t;

   state_t                  state;
   state_t                  state_next;

   logic                    req_cyc;
   logic                    req_we;
   logic [ADDR_WIDTH-1:0]   req_adr;
   logic [DATA_WIDTH-1:0]   req_dat;
   logic [SEL_WIDTH-1:0]    req_sel;

   logic                    resp_ack;
   logic                    resp_err;
   logic                    resp_rty;
   logic [DATA_WIDTH-1:0]   resp_dat;

   logic                    abort;
   logic                    accept;
   logic                    resp_any;
   logic                    abort_now;
   logic                    unused_inputs;

   assign accept    = s_wb.cyc & s_wb.stb;
   assign resp_any  = m_wb.ack | m_wb.err | m_wb.rty;
   assign abort_now = abort | ~s_wb.cyc;

   // Burst qualifiers are deliberately ignored: every beat becomes a classic cycle.
   assign unused_inputs = ^{s_wb.cti, s_wb.bte};

`ifdef WB_TIMEOUT_EN
   localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_WIDTH-1:0]    tmo_cnt;
   logic                    timeout_hit;

   // Count cycles spent waiting in REQ, restarting for every accepted request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state == IDLE && state_next == REQ) begin
         tmo_cnt <= '0;
      end else if (state == REQ) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign timeout_hit = (tmo_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; a real response always beats a timeout in the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (resp_any) begin
               state_next = abort_now ? IDLE : RESP;
            end
`ifdef WB_TIMEOUT_EN
            else if (timeout_hit) begin
               state_next = DRAIN;
            end
`endif
         end
         RESP: begin
            state_next = IDLE;
         end
`ifdef WB_TIMEOUT_EN
         DRAIN: begin
            if (resp_any) begin
               state_next = IDLE;
            end
         end
`endif
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Abort flag remembers an upstream that dropped cyc while the downstream is busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         abort <= 1'b0;
      end else if (state == REQ && state_next == REQ) begin
         abort <= abort_now;
      end else begin
         abort <= 1'b0;
      end
   end

   // Registered request, downstream strobe and one-cycle upstream status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_cyc  <= 1'b0;
         req_we   <= 1'b0;
         req_adr  <= '0;
         req_dat  <= '0;
         req_sel  <= '0;
         resp_ack <= 1'b0;
         resp_err <= 1'b0;
         resp_rty <= 1'b0;
         resp_dat <= '0;
      end else begin
         resp_ack <= 1'b0;
         resp_err <= 1'b0;
         resp_rty <= 1'b0;
         req_cyc  <= (state_next == REQ);
`ifdef WB_TIMEOUT_EN
         if (state_next == DRAIN) begin
            req_cyc <= 1'b1;
         end
         if (state == REQ && !resp_any && timeout_hit) begin
            resp_err <= ~abort_now;
         end
`endif
         if (state == IDLE && accept) begin
            req_we  <= s_wb.we;
            req_adr <= s_wb.adr;
            req_dat <= s_wb.dat_w;
            req_sel <= s_wb.sel;
         end
         if (state == REQ && resp_any) begin
            resp_dat <= m_wb.dat_r;
            if (!abort_now) begin
               resp_err <= m_wb.err;
               resp_rty <= ~m_wb.err & m_wb.rty;
               resp_ack <= ~m_wb.err & ~m_wb.rty & m_wb.ack;
            end
         end
      end
   end

   assign m_wb.cyc   = req_cyc;
   assign m_wb.stb   = req_cyc;
   assign m_wb.we    = req_we;
   assign m_wb.adr   = req_adr;
   assign m_wb.dat_w = req_dat;
   assign m_wb.sel   = req_sel;
   assign m_wb.cti   = 3'b000;
   assign m_wb.bte   = 2'b00;

   assign s_wb.ack   = resp_ack;
   assign s_wb.err   = resp_err;
   assign s_wb.rty   = resp_rty;
   assign s_wb.dat_r = resp_dat;
endmodule

// File: tb/tb_wb_req_slice.sv
// Directed testbench for wb_req_slice. Each scenario task drives the upstream
// master and a scripted downstream responder, then compares registered outputs
// one time unit after the rising edge against hand-computed values.
module tb_wb_req_slice;
   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   logic [2:0] prio_in  [4] = '{3'b110, 3'b101, 3'b011, 3'b111};
   logic [2:0] prio_exp [4] = '{3'b010, 3'b001, 3'b010, 3'b010};

   wb_req_slice_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) s_wb ();
   wb_req_slice_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m_wb ();

   wb_req_slice #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .s_wb (s_wb),
      .m_wb (m_wb)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      s_wb.cyc   = 1'b0;
      s_wb.stb   = 1'b0;
      s_wb.we    = 1'b0;
      s_wb.adr   = '0;
      s_wb.dat_w = '0;
      s_wb.sel   = '0;
      s_wb.cti   = '0;
      s_wb.bte   = '0;
      m_wb.ack   = 1'b0;
      m_wb.err   = 1'b0;
      m_wb.rty   = 1'b0;
      m_wb.dat_r = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_bus();
      step();
      step();
      vectors++;
      if ({s_wb.ack, s_wb.err, s_wb.rty} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset_status: got %b, want 000", {s_wb.ack, s_wb.err, s_wb.rty});
      end
      vectors++;
      if (s_wb.dat_r !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_dat: got %h, want 0", s_wb.dat_r);
      end
      vectors++;
      if ({m_wb.cyc, m_wb.stb, m_wb.we, m_wb.adr, m_wb.dat_w, m_wb.sel} !== 71'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_req: got cyc=%b stb=%b adr=%h, want all 0", m_wb.cyc, m_wb.stb, m_wb.adr);
      end
      vectors++;
      if ({m_wb.cti, m_wb.bte} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_cti_bte: got %b, want 00000", {m_wb.cti, m_wb.bte});
      end
      rst = 1'b0;
      step();
      vectors++;
      if (m_wb.cyc !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_release: got cyc=%b, want 0", m_wb.cyc);
      end
   endtask

   task automatic test_write();
      s_wb.cyc   = 1'b1;
      s_wb.stb   = 1'b1;
      s_wb.we    = 1'b1;
      s_wb.adr   = 32'h4000_0010;
      s_wb.dat_w = 32'hDEAD_BEEF;
      s_wb.sel   = 4'hF;
      s_wb.cti   = 3'b000;
      step();
      vectors++;
      if ({m_wb.cyc, m_wb.stb} !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL write_stb_rise: got %b, want 11", {m_wb.cyc, m_wb.stb});
      end
      vectors++;
      if ({m_wb.we, m_wb.adr, m_wb.dat_w, m_wb.sel} !== {1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF}) begin
         miscompares++;
         $display("[TB] FAIL write_fields: got we=%b adr=%h dat=%h sel=%h, want 1 40000010 deadbeef f",
                  m_wb.we, m_wb.adr, m_wb.dat_w, m_wb.sel);
      end
      vectors++;
      if ({m_wb.cti, m_wb.bte} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL write_cti: got %b, want 00000", {m_wb.cti, m_wb.bte});
      end
      for (int k = 0; k < 2; k++) begin
         step();
         vectors++;
         if ({m_wb.stb, s_wb.ack, s_wb.err, s_wb.rty} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL write_wait: got %b, want 1000", {m_wb.stb, s_wb.ack, s_wb.err, s_wb.rty});
         end
      end
      m_wb.ack = 1'b1;
      step();
      vectors++;
      if ({s_wb.ack, s_wb.err, s_wb.rty, m_wb.cyc} !== 4'b1000) begin
         miscompares++;
         $display("[TB] FAIL write_ack: got ack/err/rty/cyc=%b, want 1000", {s_wb.ack, s_wb.err, s_wb.rty, m_wb.cyc});
      end
      m_wb.ack = 1'b0;
      step();
      vectors++;
      if ({s_wb.ack, s_wb.err, s_wb.rty, m_wb.cyc} !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL write_single_no_reaccept: got ack/err/rty/cyc=%b, want 0000", {s_wb.ack, s_wb.err, s_wb.rty, m_wb.cyc});
      end
      s_wb.cyc = 1'b0;
      s_wb.stb = 1'b0;
      step();
   endtask

   task automatic test_read();
      s_wb.cyc   = 1'b1;
      s_wb.stb   = 1'b1;
      s_wb.we    = 1'b0;
      s_wb.adr   = 32'h4000_0020;
      s_wb.dat_w = '0;
      s_wb.sel   = 4'hF;
      step();
      vectors++;
      if ({m_wb.cyc, m_wb.stb, m_wb.we, m_wb.adr} !== {3'b110, 32'h4000_0020}) begin
         miscompares++;
         $display("[TB] FAIL read_req: got cyc/stb/we=%b adr=%h, want 110 40000020", {m_wb.cyc, m_wb.stb, m_wb.we}, m_wb.adr);
      end
      m_wb.ack   = 1'b1;
      m_wb.dat_r = 32'h1234_5678;
      step();
      vectors++;
      if ({s_wb.ack, s_wb.dat_r} !== {1'b1, 32'h1234_5678}) begin
         miscompares++;
         $display("[TB] FAIL read_data: got ack=%b dat=%h, want 1 12345678", s_wb.ack, s_wb.dat_r);
      end
      m_wb.ack   = 1'b0;
      m_wb.dat_r = 32'hFFFF_0000;
      step();
      vectors++;
      if ({s_wb.ack, s_wb.dat_r} !== {1'b0, 32'h1234_5678}) begin
         miscompares++;
         $display("[TB] FAIL read_hold: got ack=%b dat=%h, want 0 12345678", s_wb.ack, s_wb.dat_r);
      end
      s_wb.cyc = 1'b0;
      s_wb.stb = 1'b0;
      step();
      step();
      vectors++;
      if (s_wb.dat_r !== 32'h1234_5678) begin
         miscompares++;
         $display("[TB] FAIL read_hold_idle: got dat=%h, want 12345678", s_wb.dat_r);
      end
   endtask

   task automatic test_priority();
      for (int i = 0; i < 4; i++) begin
         s_wb.cyc = 1'b1;
         s_wb.stb = 1'b1;
         s_wb.we  = 1'b0;
         s_wb.adr = 32'h4000_0100 + 32'(i * 4);
         step();
         {m_wb.ack, m_wb.err, m_wb.rty} = prio_in[i];
         step();
         vectors++;
         if ({s_wb.ack, s_wb.err, s_wb.rty} !== prio_exp[i]) begin
            miscompares++;
            $display("[TB] FAIL prio_status[%0d]: in=%b got %b, want %b", i, prio_in[i],
                     {s_wb.ack, s_wb.err, s_wb.rty}, prio_exp[i]);
         end
         {m_wb.ack, m_wb.err, m_wb.rty} = 3'b000;
         s_wb.cyc = 1'b0;
         s_wb.stb = 1'b0;
         step();
         vectors++;
         if ({s_wb.ack, s_wb.err, s_wb.rty} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL prio_single[%0d]: got %b, want 000", i, {s_wb.ack, s_wb.err, s_wb.rty});
         end
      end
   endtask

   task automatic test_abort();
      s_wb.cyc   = 1'b1;
      s_wb.stb   = 1'b1;
      s_wb.we    = 1'b1;
      s_wb.adr   = 32'h4000_0200;
      s_wb.dat_w = 32'h0BAD_F00D;
      s_wb.sel   = 4'h3;
      step();
      s_wb.cyc = 1'b0;
      s_wb.stb = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         vectors++;
         if ({m_wb.cyc, m_wb.stb, s_wb.ack, s_wb.err, s_wb.rty, m_wb.adr, m_wb.dat_w} !==
             {5'b11000, 32'h4000_0200, 32'h0BAD_F00D}) begin
            miscompares++;
            $display("[TB] FAIL abort_hold[%0d]: got cyc/stb/ack/err/rty=%b adr=%h, want 11000 40000200", k,
                     {m_wb.cyc, m_wb.stb, s_wb.ack, s_wb.err, s_wb.rty}, m_wb.adr);
         end
      end
      m_wb.ack = 1'b1;
      step();
      vectors++;
      if ({m_wb.cyc, s_wb.ack, s_wb.err, s_wb.rty} !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL abort_no_status: got cyc/ack/err/rty=%b, want 0000", {m_wb.cyc, s_wb.ack, s_wb.err, s_wb.rty});
      end
      m_wb.ack = 1'b0;
      step();
      vectors++;
      if ({m_wb.cyc, s_wb.ack, s_wb.err, s_wb.rty} !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL abort_idle: got cyc/ack/err/rty=%b, want 0000", {m_wb.cyc, s_wb.ack, s_wb.err, s_wb.rty});
      end
   endtask

   task automatic test_burst();
      int acks = 0;
      for (int i = 0; i < 4; i++) begin
         s_wb.cyc   = 1'b1;
         s_wb.stb   = 1'b1;
         s_wb.we    = 1'b1;
         s_wb.adr   = 32'h4000_1000 + 32'(i * 4);
         s_wb.dat_w = 32'(32'h1111_1111 * (i + 1));
         s_wb.sel   = 4'hF;
         s_wb.cti   = (i == 3) ? 3'b111 : 3'b010;
         step();
         vectors++;
         if ({m_wb.cyc, m_wb.stb, m_wb.adr, m_wb.dat_w} !==
             {2'b11, 32'h4000_1000 + 32'(i * 4), 32'(32'h1111_1111 * (i + 1))}) begin
            miscompares++;
            $display("[TB] FAIL burst_beat[%0d]: got cyc/stb=%b adr=%h dat=%h, want 11 %h %h", i,
                     {m_wb.cyc, m_wb.stb}, m_wb.adr, m_wb.dat_w, 32'h4000_1000 + 32'(i * 4),
                     32'(32'h1111_1111 * (i + 1)));
         end
         vectors++;
         if (m_wb.cti !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL burst_cti[%0d]: got %b, want 000", i, m_wb.cti);
         end
         m_wb.ack   = 1'b1;
         m_wb.dat_r = 32'hA5A5_0000 + 32'(i);
         step();
         if (s_wb.ack === 1'b1 && m_wb.cyc === 1'b0) begin
            acks++;
         end
         m_wb.ack = 1'b0;
         step();
         vectors++;
         if ({m_wb.cyc, s_wb.ack} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL burst_no_dup[%0d]: got cyc/ack=%b, want 00", i, {m_wb.cyc, s_wb.ack});
         end
      end
      s_wb.cyc = 1'b0;
      s_wb.stb = 1'b0;
      s_wb.cti = 3'b000;
      vectors++;
      if (acks !== 4) begin
         miscompares++;
         $display("[TB] FAIL burst_acks: got %0d, want 4", acks);
      end
      step();
   endtask

   task automatic test_reset_mid();
      s_wb.cyc = 1'b1;
      s_wb.stb = 1'b1;
      s_wb.we  = 1'b0;
      s_wb.adr = 32'h4000_3000;
      step();
      vectors++;
      if (m_wb.cyc !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rstmid_pre: got cyc=%b, want 1", m_wb.cyc);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({m_wb.cyc, m_wb.stb, m_wb.adr, s_wb.dat_r} !== 66'h0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_clear: got cyc/stb=%b adr=%h dat=%h, want all 0",
                  {m_wb.cyc, m_wb.stb}, m_wb.adr, s_wb.dat_r);
      end
      s_wb.cyc = 1'b0;
      s_wb.stb = 1'b0;
      step();
      rst = 1'b0;
      step();
      vectors++;
      if ({m_wb.cyc, s_wb.ack} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL rstmid_idle: got cyc/ack=%b, want 00", {m_wb.cyc, s_wb.ack});
      end
   endtask

`ifdef WB_TIMEOUT_EN
   task automatic test_timeout();
      s_wb.cyc = 1'b1;
      s_wb.stb = 1'b1;
      s_wb.we  = 1'b0;
      s_wb.adr = 32'h4000_4000;
      step();
      for (int k = 1; k < 8; k++) begin
         step();
         vectors++;
         if ({m_wb.stb, s_wb.err} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL tmo_wait[%0d]: got stb/err=%b, want 10", k, {m_wb.stb, s_wb.err});
         end
      end
      step();
      vectors++;
      if ({m_wb.stb, s_wb.err, s_wb.ack, s_wb.rty} !== 4'b1100) begin
         miscompares++;
         $display("[TB] FAIL tmo_err: got stb/err/ack/rty=%b, want 1100", {m_wb.stb, s_wb.err, s_wb.ack, s_wb.rty});
      end
      s_wb.cyc = 1'b0;
      s_wb.stb = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         vectors++;
         if ({m_wb.cyc, m_wb.stb, s_wb.err, m_wb.adr} !== {3'b110, 32'h4000_4000}) begin
            miscompares++;
            $display("[TB] FAIL tmo_drain_hold[%0d]: got cyc/stb/err=%b adr=%h, want 110 40004000", k,
                     {m_wb.cyc, m_wb.stb, s_wb.err}, m_wb.adr);
         end
      end
      m_wb.ack   = 1'b1;
      m_wb.dat_r = 32'hBAD0_BAD0;
      step();
      vectors++;
      if ({m_wb.cyc, s_wb.ack, s_wb.err, s_wb.rty, s_wb.dat_r} !== {4'b0000, 32'h0}) begin
         miscompares++;
         $display("[TB] FAIL tmo_discard: got cyc/ack/err/rty=%b dat=%h, want 0000 0",
                  {m_wb.cyc, s_wb.ack, s_wb.err, s_wb.rty}, s_wb.dat_r);
      end
      m_wb.ack = 1'b0;
      step();
      s_wb.cyc = 1'b1;
      s_wb.stb = 1'b1;
      s_wb.adr = 32'h4000_5000;
      step();
      vectors++;
      if ({m_wb.stb, m_wb.adr} !== {1'b1, 32'h4000_5000}) begin
         miscompares++;
         $display("[TB] FAIL tmo_next_req: got stb=%b adr=%h, want 1 40005000", m_wb.stb, m_wb.adr);
      end
      m_wb.ack   = 1'b1;
      m_wb.dat_r = 32'hCAFE_F00D;
      step();
      vectors++;
      if ({s_wb.ack, s_wb.err, s_wb.dat_r} !== {2'b10, 32'hCAFE_F00D}) begin
         miscompares++;
         $display("[TB] FAIL tmo_next_resp: got ack/err=%b dat=%h, want 10 cafef00d",
                  {s_wb.ack, s_wb.err}, s_wb.dat_r);
      end
      m_wb.ack = 1'b0;
      s_wb.cyc = 1'b0;
      s_wb.stb = 1'b0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_priority();
      test_abort();
      test_burst();
      test_reset_mid();
`ifdef WB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no completion after 100000 time units, want $finish");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
